gate_exerciser: RTL and testbench
=================================

GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 SHALL have parameter SETTLE, default 3, giving the cycles each input vector is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request one exercise run.
REQ-005 SHALL have port x, output, 1 bit: first operand driven to the 2-input AND under test.
REQ-006 SHALL have port y, output, 1 bit: second operand driven to the 2-input AND under test.
REQ-007 SHALL have port f, input, 1 bit: response of the gate under test.
REQ-008 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-009 SHALL have port done, output, 1 bit: high while results are valid.
REQ-010 SHALL have port pass, output, 1 bit: high when done is high and no mismatch was recorded.
REQ-011 SHALL have port err_count, output, 3 bits: number of mismatching vectors, 0..4.
REQ-012 SHALL have port fail_vec, output, 4 bits: bit v set when vector v mismatched.

Function
REQ-013 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE, with all outputs registered.
REQ-014 SHALL move IDLE->DRIVE with vector index v=0 on the edge where start=1, clearing err_count and fail_vec on that edge.
REQ-015 SHALL drive x=v[1] and y=v[0] throughout DRIVE and SAMPLE, giving the vector order 00, 01, 10, 11.
REQ-016 SHALL remain in DRIVE for exactly SETTLE cycles, counted by a 4-bit down-counter, then enter SAMPLE.
REQ-017 SHALL compare f against x&y on the edge leaving SAMPLE; on mismatch it SHALL set fail_vec[v] and increment err_count.
REQ-018 SHALL go SAMPLE->DRIVE with v+1 when v<3, and SAMPLE->DONE when v=3.
REQ-019 SHALL enter DONE exactly 4*(SETTLE+1) rising edges after the start edge, which is 16 edges at the default.
REQ-020 SHALL hold busy=1 in DRIVE and SAMPLE, and busy=0 in IDLE and DONE.
REQ-021 SHALL hold done=1 only in DONE, with pass = done AND (err_count==0).
REQ-022 SHALL drive x=0 and y=0 in IDLE and DONE.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL behave on start=1 in DONE exactly as on start=1 in IDLE: results cleared, next state DRIVE with v=0.
REQ-025 SHALL hold err_count and fail_vec stable in DONE until the next run begins or reset asserts.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, force state IDLE, v=0, counter=0, x=0, y=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0.
REQ-027 SHALL discard any run in progress when rst asserts mid-run, leaving no partial results.
REQ-028 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with GATE_EXERCISER_LOOP_EN defined, go DONE->DRIVE with v=0 automatically one cycle after entering DONE, so done pulses high for 1 cycle per run and each run restarts with cleared results.
REQ-030 SHALL, without GATE_EXERCISER_LOOP_EN, stay in DONE until start or rst.

Verification
REQ-031 SHALL cover: f=x&y from a correct AND, start pulsed -> done after 16 cycles, pass=1, err_count=0, fail_vec=0000.
REQ-032 SHALL cover: f stuck at 0 -> fail_vec=1000, err_count=1, pass=0.
REQ-033 SHALL cover: f=x|y -> fail_vec=0110, err_count=2; then f=~(x&y) with start in DONE -> fail_vec=1111, err_count=4.
REQ-034 SHALL cover: start pulsed again at cycle 5 of a run -> ignored, done still at cycle 16 with results unchanged.
REQ-035 SHALL cover: rst asserted at cycle 6 of a run -> all outputs 0 immediately, IDLE, and a clean rerun passes.
REQ-036 SHALL cover: SETTLE=1 -> done at cycle 8; with GATE_EXERCISER_LOOP_EN -> done pulses every 9 cycles.

Source files
------------

// File: rtl/gate_exerciser.sv
// Exhaustive 2-input AND tester: walks vectors 00,01,10,11, settles, samples f, tallies mismatches.
// Optional GATE_EXERCISER_LOOP_EN: rerun automatically one cycle after each completed run.
module gate_exerciser #(
  parameter int SETTLE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  // state  | meaning
  // IDLE   | waiting for start, operands parked at 0
  // DRIVE  | current vector applied, settle counter running
  // SAMPLE | vector settled, f compared on the exit edge
  // DONE   | results valid and held
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [1:0] v;
  logic [1:0] v_next;
  logic [3:0] cnt;
  logic       mismatch;
  logic [2:0] err_next;
  logic       launch;

  assign v_next   = v + 2'd1;
  assign mismatch = f != (x & y);
  assign err_next = err_count + {2'b00, mismatch};

`ifdef GATE_EXERCISER_LOOP_EN
  assign launch = ((state == IDLE) && start) || (state == DONE);
`else
  assign launch = ((state == IDLE) || (state == DONE)) && start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      v         <= 2'd0;
      cnt       <= 4'd0;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else if (launch) begin
      state     <= DRIVE;
      v         <= 2'd0;
      cnt       <= CNT_LOAD;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      case (state)
        DRIVE: begin
          if (cnt == 4'd0) state <= SAMPLE;
          else             cnt   <= cnt - 4'd1;
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_vec[v] <= 1'b1;
            err_count   <= err_next;
          end
          if (v == 2'd3) begin
            state <= DONE;
            v     <= 2'd0;
            x     <= 1'b0;
            y     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 3'd0);
          end else begin
            state <= DRIVE;
            v     <= v_next;
            cnt   <= CNT_LOAD;
            x     <= v_next[1];
            y     <= v_next[0];
          end
        end
        default: ;  // IDLE and DONE hold until launch
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: SETTLE=3 and SETTLE=1 instances driving modelled gates.
module tb_gate_exerciser;

  logic       clk = 1'b0;
  logic       rst, start, start1;
  logic       x, y, f, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic       x1, y1, f1, busy1, done1, pass1;
  logic [2:0] err_count1;
  logic [3:0] fail_vec1;
  logic [1:0] gmode;
  int         checks = 0;
  int         errors = 0;

  gate_exerciser #(.SETTLE(3)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .f(f),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_exerciser #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .f(f1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1), .fail_vec(fail_vec1)
  );

  always #5 clk = ~clk;

  // 0: good AND, 1: stuck-at-0, 2: OR, 3: NAND
  always_comb begin
    case (gmode)
      2'd0:    f = x & y;
      2'd1:    f = 1'b0;
      2'd2:    f = x | y;
      default: f = ~(x & y);
    endcase
  end
  assign f1 = x1 & y1;

  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int k);
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (sel ? done1 : done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int k;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; gmode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x, y, busy, done, pass, err_count, fail_vec} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {x, y, busy, done, pass, err_count, fail_vec});
    end
    checks++;
    if ({x1, y1, busy1, done1, pass1, err_count1, fail_vec1} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs_s1: got %b expected 0", {x1, y1, busy1, done1, pass1, err_count1, fail_vec1});
    end
    rst = 1'b0;
    pulse_start(1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_after_reset: busy got %b expected 1", busy);
    end
    wait_done(1'b0, k);
  endtask

  task automatic test_and_pass;
    int         k;
    logic [1:0] ev;
    gmode = 2'd0;
    pulse_start(1'b0);
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        k = i;
        break;
      end
      ev = 2'(i / 4);
      checks++;
      if ({x, y, busy} !== {ev, 1'b1}) begin
        errors++;
        $display("FAIL drive_vector cycle %0d: got xy=%b busy=%b expected xy=%b busy=1", i, {x, y}, busy, ev);
      end
    end
    checks++;
    if (k !== 16) begin
      errors++;
      $display("FAIL and_done_latency: got %0d expected 16", k);
    end
    checks++;
    if ({pass, err_count, fail_vec, busy, x, y} !== {1'b1, 3'd0, 4'b0000, 3'b000}) begin
      errors++;
      $display("FAIL and_results: got pass=%b err=%0d fail_vec=%b busy=%b xy=%b expected pass=1 err=0 fail_vec=0000 busy=0 xy=00",
               pass, err_count, fail_vec, busy, {x, y});
    end
  endtask

  task automatic test_stuck0;
    int k;
    gmode = 2'd1;
    pulse_start(1'b0);
    wait_done(1'b0, k);
    checks++;
    if (k !== 16) begin
      errors++;
      $display("FAIL stuck0_latency: got %0d expected 16", k);
    end
    checks++;
    if ({pass, err_count, fail_vec} !== {1'b0, 3'd1, 4'b1000}) begin
      errors++;
      $display("FAIL stuck0_results: got pass=%b err=%0d fail_vec=%b expected pass=0 err=1 fail_vec=1000",
               pass, err_count, fail_vec);
    end
  endtask

  task automatic test_or_then_nand;
    int k;
    gmode = 2'd2;
    pulse_start(1'b0);
    wait_done(1'b0, k);
    checks++;
    if ({k == 16, pass, err_count, fail_vec} !== {1'b1, 1'b0, 3'd2, 4'b0110}) begin
      errors++;
      $display("FAIL or_results: got cycles=%0d pass=%b err=%0d fail_vec=%b expected cycles=16 pass=0 err=2 fail_vec=0110",
               k, pass, err_count, fail_vec);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({done, busy, err_count, fail_vec} !== {1'b1, 1'b0, 3'd2, 4'b0110}) begin
      errors++;
      $display("FAIL done_hold: got done=%b busy=%b err=%0d fail_vec=%b expected done=1 busy=0 err=2 fail_vec=0110",
               done, busy, err_count, fail_vec);
    end
    gmode = 2'd3;
    pulse_start(1'b0);
    checks++;
    if ({done, busy, err_count, fail_vec} !== {1'b0, 1'b1, 3'd0, 4'b0000}) begin
      errors++;
      $display("FAIL restart_from_done_clear: got done=%b busy=%b err=%0d fail_vec=%b expected done=0 busy=1 err=0 fail_vec=0000",
               done, busy, err_count, fail_vec);
    end
    wait_done(1'b0, k);
    checks++;
    if ({k == 16, pass, err_count, fail_vec} !== {1'b1, 1'b0, 3'd4, 4'b1111}) begin
      errors++;
      $display("FAIL nand_results: got cycles=%0d pass=%b err=%0d fail_vec=%b expected cycles=16 pass=0 err=4 fail_vec=1111",
               k, pass, err_count, fail_vec);
    end
  endtask

  task automatic test_restart_ignored;
    int k;
    gmode = 2'd1;
    pulse_start(1'b0);
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      start = (i == 5);
      if (done) begin
        k = i;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if ({k == 16, pass, err_count, fail_vec} !== {1'b1, 1'b0, 3'd1, 4'b1000}) begin
      errors++;
      $display("FAIL restart_ignored: got cycles=%0d pass=%b err=%0d fail_vec=%b expected cycles=16 pass=0 err=1 fail_vec=1000",
               k, pass, err_count, fail_vec);
    end
  endtask

  task automatic test_reset_midrun;
    int k;
    gmode = 2'd3;
    pulse_start(1'b0);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({busy, err_count, fail_vec} !== {1'b1, 3'd1, 4'b0001}) begin
      errors++;
      $display("FAIL midrun_partial: got busy=%b err=%0d fail_vec=%b expected busy=1 err=1 fail_vec=0001",
               busy, err_count, fail_vec);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({x, y, busy, done, pass, err_count, fail_vec} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset_midrun: got %b expected 0", {x, y, busy, done, pass, err_count, fail_vec});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err_count, fail_vec} !== 9'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b err=%0d fail_vec=%b expected all 0",
               busy, done, err_count, fail_vec);
    end
    gmode = 2'd0;
    pulse_start(1'b0);
    wait_done(1'b0, k);
    checks++;
    if ({k == 16, pass, err_count, fail_vec} !== {1'b1, 1'b1, 3'd0, 4'b0000}) begin
      errors++;
      $display("FAIL rerun_after_reset: got cycles=%0d pass=%b err=%0d fail_vec=%b expected cycles=16 pass=1 err=0 fail_vec=0000",
               k, pass, err_count, fail_vec);
    end
  endtask

  task automatic test_settle1;
    int k;
    pulse_start(1'b1);
    wait_done(1'b1, k);
    checks++;
    if ({k == 8, pass1, err_count1, fail_vec1} !== {1'b1, 1'b1, 3'd0, 4'b0000}) begin
      errors++;
      $display("FAIL settle1_run: got cycles=%0d pass=%b err=%0d fail_vec=%b expected cycles=8 pass=1 err=0 fail_vec=0000",
               k, pass1, err_count1, fail_vec1);
    end
  endtask

  task automatic test_loop;
    int k;
    test_settle1();
    for (int n = 0; n < 3; n++) begin
      wait_done(1'b1, k);
      checks++;
      if (k !== 9) begin
        errors++;
        $display("FAIL loop_period run %0d: got %0d expected 9", n, k);
      end
      checks++;
      if ({pass1, err_count1, fail_vec1} !== {1'b1, 3'd0, 4'b0000}) begin
        errors++;
        $display("FAIL loop_results run %0d: got pass=%b err=%0d fail_vec=%b expected pass=1 err=0 fail_vec=0000",
                 n, pass1, err_count1, fail_vec1);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef GATE_EXERCISER_LOOP_EN
    test_loop();
`else
    test_and_pass();
    test_stuck0();
    test_or_then_nand();
    test_restart_ignored();
    test_reset_midrun();
    test_settle1();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
